// File: rtl/rat_io_pkg.sv
// Shared RAT I/O definitions: port IDs, UART RX status bit positions and receive FSM states.
package rat_io_pkg;

  localparam logic [7:0] SWITCHES_ID       = 8'h20;
  localparam logic [7:0] LEDS_ID           = 8'h40;
  localparam logic [7:0] SEVSEG_ID         = 8'h81;
  localparam logic [7:0] UART_RX_DATA_ID   = 8'h21;
  localparam logic [7:0] UART_RX_STATUS_ID = 8'h22;

  localparam int ST_NE   = 0;
  localparam int ST_FULL = 1;
  localparam int ST_OVR  = 2;
  localparam int ST_FERR = 3;
  localparam int ST_PERR = 4;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4
  } rx_state_e;

  // The status byte has only three bits for the occupancy count.
  function automatic logic [2:0] sat_count(input logic [4:0] c);
    return (c > 5'd7) ? 3'd7 : c[2:0];
  endfunction

endpackage

// File: rtl/rat_byte_fifo.sv
// Synchronous byte FIFO with a combinational head; push on full is accepted only alongside a pop.
module rat_byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   push,
  input  logic [7:0]             push_data,
  input  logic                   pop,
  output logic [7:0]             head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rat_uart_rx_port.sv
// UART receiver on the RAT IN-port bus: 8N1 deserialiser, byte FIFO, data/status read mux.
// Optional even parity bit enabled by defining UART_RX_PARITY_EN.
//
// state     | meaning
// RX_IDLE   | line idle, waiting for a genuine falling edge
// RX_START  | half a bit time into start bit; confirm it is still low
// RX_DATA   | sampling 8 data bits LSB first, one per bit time
// RX_PARITY | sampling the even-parity bit (UART_RX_PARITY_EN only)
// RX_STOP   | sampling stop bit; push byte or flag framing error
module rat_uart_rx_port
  import rat_io_pkg::*;
#(
  parameter int         CLK_FREQ   = 50_000_000,
  parameter int         BAUD       = 115200,
  parameter int         FIFO_DEPTH = 4,
  parameter logic [7:0] DATA_ID    = UART_RX_DATA_ID,
  parameter logic [7:0] STATUS_ID  = UART_RX_STATUS_ID
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       RX,
  input  logic [7:0] PORT_ID,
  input  logic       IO_STRB,
  input  logic [7:0] OUT_PORT,
  output logic [7:0] IN_PORT_OUT,
  output logic       INT_REQ
);

  localparam int DIVISOR = CLK_FREQ / BAUD;
  localparam int HALF    = DIVISOR / 2;
  localparam int CNT_W   = $clog2(DIVISOR + 1);

  logic [1:0]       rx_sync;
  logic [1:0]       prime;
  logic             rx_s;
  logic             rx_prev;
  logic             fall;

  rx_state_e        state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic             cnt_done;
  logic             stop_smp;
  logic             par_ok;

  logic             push;
  logic             pop_req;
  logic             clr_strb;
  logic [7:0]       head;
  logic             full;
  logic             empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;

  logic             ovr;
  logic             ferr;
  logic             perr;
  logic             ovr_set;
  logic             ferr_set;
  logic [7:0]       status;

`ifdef UART_RX_PARITY_EN
  logic             par_bad;
  logic             perr_set;
  logic             unused_out_bits;
  assign unused_out_bits = ^{OUT_PORT[7:5], OUT_PORT[1:0]};
`else
  logic             unused_out_bits;
  assign unused_out_bits = ^{OUT_PORT[7:4], OUT_PORT[1:0]};
`endif

  // Sync flops reset high; prime keeps edge detection off until they carry real line data,
  // so a frame in progress at reset release does not look like a new start bit.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      rx_sync <= 2'b11;
      prime   <= 2'b00;
      rx_prev <= 1'b0;
    end else begin
      rx_sync <= {rx_sync[0], RX};
      prime   <= {prime[0], 1'b1};
      rx_prev <= rx_s & prime[1];
    end
  end

  assign rx_s     = rx_sync[1];
  assign fall     = rx_prev & ~rx_s;
  assign cnt_done = (cnt == '0);
  assign stop_smp = (state == RX_STOP) && cnt_done;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state   <= RX_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
`ifdef UART_RX_PARITY_EN
      par_bad <= 1'b0;
`endif
    end else begin
      case (state)
        RX_IDLE: begin
          if (fall) begin
            state   <= RX_START;
            cnt     <= CNT_W'(HALF - 1);
            bit_idx <= '0;
`ifdef UART_RX_PARITY_EN
            par_bad <= 1'b0;
`endif
          end
        end
        RX_START: begin
          if (cnt_done) begin
            cnt   <= CNT_W'(DIVISOR - 1);
            state <= rx_s ? RX_IDLE : RX_DATA;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt_done) begin
            shift   <= {rx_s, shift[7:1]};
            cnt     <= CNT_W'(DIVISOR - 1);
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= RX_PARITY;
`else
              state <= RX_STOP;
`endif
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        RX_PARITY: begin
          if (cnt_done) begin
            par_bad <= (rx_s != ^shift);
            cnt     <= CNT_W'(DIVISOR - 1);
            state   <= RX_STOP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
`endif
        RX_STOP: begin
          if (cnt_done) state <= RX_IDLE;
          else          cnt   <= cnt - 1'b1;
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

`ifdef UART_RX_PARITY_EN
  assign par_ok   = ~par_bad;
  assign perr_set = (state == RX_PARITY) && cnt_done && (rx_s != ^shift);
`else
  assign par_ok   = 1'b1;
`endif

  assign push     = stop_smp & rx_s & par_ok;
  assign ferr_set = stop_smp & ~rx_s;
  assign pop_req  = IO_STRB && (PORT_ID == DATA_ID);
  assign clr_strb = IO_STRB && (PORT_ID == STATUS_ID);
  assign ovr_set  = push & full & ~pop_req;

  rat_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .CLK       (CLK),
    .RESET     (RESET),
    .push      (push),
    .push_data (shift),
    .pop       (pop_req),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .count     (fifo_count)
  );

  // Sticky flags: a same-cycle set beats the write-1-to-clear.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      ovr  <= 1'b0;
      ferr <= 1'b0;
    end else begin
      ovr  <= ovr_set  | (ovr  & ~(clr_strb & OUT_PORT[ST_OVR]));
      ferr <= ferr_set | (ferr & ~(clr_strb & OUT_PORT[ST_FERR]));
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) perr <= 1'b0;
    else       perr <= perr_set | (perr & ~(clr_strb & OUT_PORT[ST_PERR]));
  end
`else
  assign perr = 1'b0;
`endif

  always_comb begin
    status                = '0;
    status[ST_NE]         = ~empty;
    status[ST_FULL]       = full;
    status[ST_OVR]        = ovr;
    status[ST_FERR]       = ferr;
    status[ST_PERR]       = perr;
    status[7:5]           = sat_count(5'(fifo_count));
  end

  always_comb begin
    IN_PORT_OUT = 8'h00;
    if (PORT_ID == DATA_ID)        IN_PORT_OUT = empty ? 8'h00 : head;
    else if (PORT_ID == STATUS_ID) IN_PORT_OUT = status;
  end

  assign INT_REQ = ~empty;

endmodule

// File: tb/tb_rat_uart_rx_port.sv
// Directed bench for rat_uart_rx_port at default parameters (434 clocks per bit).
module tb_rat_uart_rx_port;

  localparam int BIT = 434;
  localparam logic [7:0] DID = 8'h21;
  localparam logic [7:0] SID = 8'h22;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       RX;
  logic [7:0] PORT_ID;
  logic       IO_STRB;
  logic [7:0] OUT_PORT;
  logic [7:0] IN_PORT_OUT;
  logic       INT_REQ;

  int checks = 0;
  int passed = 0;
  logic [7:0] v;
  logic [7:0] b;

  rat_uart_rx_port dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .RX          (RX),
    .PORT_ID     (PORT_ID),
    .IO_STRB     (IO_STRB),
    .OUT_PORT    (OUT_PORT),
    .IN_PORT_OUT (IN_PORT_OUT),
    .INT_REQ     (INT_REQ)
  );

  always #5 CLK = ~CLK;

  task automatic cycles(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [7:0] id, output logic [7:0] val);
    @(negedge CLK);
    PORT_ID = id;
    #1;
    val = IN_PORT_OUT;
  endtask

  task automatic strobe(input logic [7:0] id, input logic [7:0] d);
    @(negedge CLK);
    PORT_ID  = id;
    OUT_PORT = d;
    IO_STRB  = 1'b1;
    @(negedge CLK);
    IO_STRB  = 1'b0;
    OUT_PORT = 8'h00;
  endtask

  // Drives start, data LSB first, optional parity (even, optionally inverted), and stop.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par_flip);
    RX = 1'b0;
    cycles(BIT);
    for (int i = 0; i < 8; i++) begin
      RX = d[i];
      cycles(BIT);
    end
`ifdef UART_RX_PARITY_EN
    RX = (^d) ^ par_flip;
    cycles(BIT);
`endif
    RX = stop_bit;
    cycles(BIT);
    RX = 1'b1;
    cycles(20);
  endtask

  initial begin
    RESET = 1'b1; RX = 1'b1; PORT_ID = 8'h00; IO_STRB = 1'b0; OUT_PORT = 8'h00;
    cycles(4);
    RESET = 1'b0;
    cycles(2);
    check("reset_int", {7'b0, INT_REQ}, 8'h00);
    rd(8'h00, v); check("reset_nomatch", v, 8'h00);
    rd(SID, v);   check("reset_status", v, 8'h00);
    cycles(20);

    send_frame(8'hA5, 1'b1, 1'b0);
    check("a5_int", {7'b0, INT_REQ}, 8'h01);
    rd(SID, v);   check("a5_status", v, 8'h21);
    rd(DID, v);   check("a5_data", v, 8'hA5);
    rd(8'h20, v); check("a5_nomatch", v, 8'h00);
    strobe(DID, 8'h00);
    check("a5_pop_int", {7'b0, INT_REQ}, 8'h00);
    rd(SID, v);   check("a5_pop_status", v, 8'h00);
    rd(DID, v);   check("a5_empty_data", v, 8'h00);

    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 1'b0);
    rd(SID, v);   check("ovr_status", v, 8'h87);
    for (int i = 1; i <= 4; i++) begin
      rd(DID, v); check("ovr_pop_data", v, 8'(i));
      strobe(DID, 8'h00);
    end
    check("ovr_drained_int", {7'b0, INT_REQ}, 8'h00);
    rd(SID, v);   check("ovr_sticky", v, 8'h04);
    strobe(SID, 8'h04);
    rd(SID, v);   check("ovr_clear", v, 8'h00);

    send_frame(8'h3C, 1'b0, 1'b0);
    rd(SID, v);   check("ferr_status", v, 8'h08);
    check("ferr_int", {7'b0, INT_REQ}, 8'h00);
    strobe(SID, 8'hF3);
    rd(SID, v);   check("ferr_other_bits", v, 8'h08);
    strobe(SID, 8'h08);
    rd(SID, v);   check("ferr_clear", v, 8'h00);

    RX = 1'b0;
    cycles(100);
    RX = 1'b1;
    cycles(300);
    rd(SID, v);   check("glitch_status", v, 8'h00);
    check("glitch_int", {7'b0, INT_REQ}, 8'h00);
    send_frame(8'h5A, 1'b1, 1'b0);
    rd(DID, v);   check("after_glitch_data", v, 8'h5A);
    strobe(DID, 8'h00);

    send_frame(8'h11, 1'b1, 1'b0);
    rd(SID, v);   check("pre_reset_status", v, 8'h21);
    b = 8'h0F;
    RX = 1'b0;
    cycles(BIT);
    for (int i = 0; i < 4; i++) begin
      RX = b[i];
      cycles(BIT);
    end
    RX = b[4];
    cycles(200);
    RESET = 1'b1;
    cycles(3);
    RESET = 1'b0;
    cycles(2);
    rd(SID, v);   check("mid_reset_status", v, 8'h00);
    check("mid_reset_int", {7'b0, INT_REQ}, 8'h00);
    cycles(BIT - 206);
    for (int i = 5; i < 8; i++) begin
      RX = b[i];
      cycles(BIT);
    end
`ifdef UART_RX_PARITY_EN
    RX = ^b;
    cycles(BIT);
`endif
    RX = 1'b1;
    cycles(BIT + 50);
    rd(SID, v);   check("post_partial_status", v, 8'h00);
    send_frame(8'h7E, 1'b1, 1'b0);
    rd(DID, v);   check("after_reset_data", v, 8'h7E);
    rd(SID, v);   check("after_reset_status", v, 8'h21);
    strobe(DID, 8'h00);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h81, 1'b1, 1'b1);
    rd(SID, v);   check("perr_status", v, 8'h10);
    strobe(SID, 8'h10);
    rd(SID, v);   check("perr_clear", v, 8'h00);
    send_frame(8'h81, 1'b1, 1'b0);
    rd(DID, v);   check("par_ok_data", v, 8'h81);
    rd(SID, v);   check("par_ok_status", v, 8'h21);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
